// File: rtl/kamus_csr_counters_pkg.sv
// rtl/kamus_csr_counters_pkg.sv - counter/timer CSR addresses, access ops and write-value helper
package kamus_csr_counters_pkg;

    localparam int HPM_MAX = 8;

    typedef enum logic [11:0] {
        MCOUNTINHIBIT = 12'h320,
        MTIME         = 12'h7C0,
        MTIMEH        = 12'h7C1,
        MTIMECMP      = 12'h7C2,
        MTIMECMPH     = 12'h7C3,
        MCYCLE        = 12'hB00,
        MINSTRET      = 12'hB02,
        MHPMCOUNTER3  = 12'hB03,
        MCYCLEH       = 12'hB80,
        MINSTRETH     = 12'hB82,
        MHPMCOUNTER3H = 12'hB83,
        CYCLE         = 12'hC00,
        TIME          = 12'hC01,
        INSTRET       = 12'hC02,
        CYCLEH        = 12'hC80,
        TIMEH         = 12'hC81,
        INSTRETH      = 12'hC82
    } csr_e;

    typedef enum logic [1:0] {
        F2_PRIV  = 2'b00,
        F2_CSRRW = 2'b01,
        F2_CSRRS = 2'b10,
        F2_CSRRC = 2'b11
    } funct2_system_t;

    function automatic logic [31:0] csr_wval(input logic [1:0] op, input logic [31:0] old,
                                             input logic [31:0] wdata);
        case (op)
            F2_CSRRS: csr_wval = old | wdata;
            F2_CSRRC: csr_wval = old & ~wdata;
            default:  csr_wval = wdata;
        endcase
    endfunction

endpackage

// File: rtl/kamus_csr_counters_if.sv
// rtl/kamus_csr_counters_if.sv - single-cycle CSR access port of the counter bank
interface kamus_csr_counters_if;
    logic        csr_valid_i;
    logic [11:0] csr_addr_i;
    logic [1:0]  csr_op_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;
    logic        csr_illegal_o;

    modport master (
        output csr_valid_i, csr_addr_i, csr_op_i, csr_wdata_i,
        input  csr_rdata_o, csr_hit_o, csr_illegal_o
    );

    modport slave (
        input  csr_valid_i, csr_addr_i, csr_op_i, csr_wdata_i,
        output csr_rdata_o, csr_hit_o, csr_illegal_o
    );
endinterface

// File: rtl/kamus_counter.sv
// rtl/kamus_counter.sv - W-bit counter with 32-bit half writes; a write beats the increment
module kamus_counter #(
    parameter int W = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         inhibit_i,
    input  logic         wr_lo_i,
    input  logic         wr_hi_i,
    input  logic [31:0]  wdata_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (wr_lo_i) begin
            cnt_o[31:0] <= wdata_i;
        end else if (wr_hi_i) begin
            cnt_o[W-1:32] <= wdata_i[W-33:0];
        end else if (inc_i && !inhibit_i) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/kamus_csr_counters.sv
// rtl/kamus_csr_counters.sv - cycle/instret/mtime/hpm counter CSR bank with machine timer interrupt
module kamus_csr_counters
    import kamus_csr_counters_pkg::*;
#(
    parameter int CNT_WIDTH = 64,
    parameter int NUM_HPM   = 4,
    parameter int TIME_DIV  = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    kamus_csr_counters_if.slave                   csr,
    input  logic                                  instr_retire_i,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
    output logic                                  timer_irq_o
);

    // Counter slots: 0 mcycle, 1 minstret, 2 mtime, 3.. hpm
    localparam int          NCNT     = 3 + NUM_HPM;
    localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
    localparam logic [7:0]  PS_TC    = 8'(TIME_DIV - 1);

    logic [CNT_WIDTH-1:0] cnt [NCNT];
    logic [CNT_WIDTH-1:0] mtimecmp;
    logic [31:0]          inhibit, old_val, wr_val;
    logic [7:0]           presc;
    logic                 tick;
    logic [NCNT-1:0]      sel_cnt, inc_vec, inh_vec;
    logic                 sel_hi, sel_cmp, sel_inh, hit, ro, hpm_sel, is_write, do_wr;
    logic [11:0]          hpm_lo_off, hpm_hi_off, hpm_off;

    assign hpm_lo_off = csr.csr_addr_i - 12'(MHPMCOUNTER3);
    assign hpm_hi_off = csr.csr_addr_i - 12'(MHPMCOUNTER3H);

    always_comb begin
        sel_cnt = '0;
        sel_hi  = 1'b0;
        sel_cmp = 1'b0;
        sel_inh = 1'b0;
        hit     = 1'b1;
        ro      = 1'b0;
        hpm_sel = 1'b0;
        hpm_off = '0;
        case (csr.csr_addr_i)
            CYCLE:         begin sel_cnt[0] = 1'b1; ro = 1'b1; end
            CYCLEH:        begin sel_cnt[0] = 1'b1; sel_hi = 1'b1; ro = 1'b1; end
            INSTRET:       begin sel_cnt[1] = 1'b1; ro = 1'b1; end
            INSTRETH:      begin sel_cnt[1] = 1'b1; sel_hi = 1'b1; ro = 1'b1; end
            TIME:          begin sel_cnt[2] = 1'b1; ro = 1'b1; end
            TIMEH:         begin sel_cnt[2] = 1'b1; sel_hi = 1'b1; ro = 1'b1; end
            MCYCLE:        sel_cnt[0] = 1'b1;
            MCYCLEH:       begin sel_cnt[0] = 1'b1; sel_hi = 1'b1; end
            MINSTRET:      sel_cnt[1] = 1'b1;
            MINSTRETH:     begin sel_cnt[1] = 1'b1; sel_hi = 1'b1; end
            MTIME:         sel_cnt[2] = 1'b1;
            MTIMEH:        begin sel_cnt[2] = 1'b1; sel_hi = 1'b1; end
            MTIMECMP:      sel_cmp = 1'b1;
            MTIMECMPH:     begin sel_cmp = 1'b1; sel_hi = 1'b1; end
            MCOUNTINHIBIT: sel_inh = 1'b1;
            default: begin
                if (hpm_lo_off < 12'(HPM_MAX)) begin
                    hpm_sel = 1'b1;
                    hpm_off = hpm_lo_off;
                end else if (hpm_hi_off < 12'(HPM_MAX)) begin
                    hpm_sel = 1'b1;
                    hpm_off = hpm_hi_off;
                    sel_hi  = 1'b1;
                end else begin
                    hit = 1'b0;
                end
                // hpm slots past NUM_HPM exist in the map but read 0 and reject writes
                ro = hpm_sel && (hpm_off >= 12'(NUM_HPM));
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (hpm_sel && hpm_off == 12'(i)) sel_cnt[3+i] = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        old_val = '0;
        for (int k = 0; k < NCNT; k++) begin
            if (sel_cnt[k]) old_val = sel_hi ? 32'(cnt[k] >> 32) : cnt[k][31:0];
        end
        if (sel_cmp) old_val = sel_hi ? 32'(mtimecmp >> 32) : mtimecmp[31:0];
        if (sel_inh) old_val = inhibit;
    end

    assign wr_val   = csr_wval(csr.csr_op_i, old_val, csr.csr_wdata_i);
    assign is_write = csr.csr_valid_i && hit &&
                      (csr.csr_op_i == F2_CSRRW ||
                       (csr.csr_op_i != F2_PRIV && csr.csr_wdata_i != 32'h0));
    assign do_wr    = is_write && !ro;

    assign csr.csr_rdata_o   = csr.csr_valid_i ? old_val : 32'h0;
    assign csr.csr_hit_o     = csr.csr_valid_i && hit;
    assign csr.csr_illegal_o = is_write && ro;

    assign tick       = (presc == PS_TC);
    assign inc_vec[0] = 1'b1;
    assign inc_vec[1] = instr_retire_i;
    assign inc_vec[2] = tick;
    assign inh_vec[0] = inhibit[0];
    assign inh_vec[1] = inhibit[2];
    assign inh_vec[2] = 1'b0;

    for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm_ctl
        assign inc_vec[3+i] = hpm_event_i[i];
        assign inh_vec[3+i] = inhibit[3+i];
    end

    for (genvar k = 0; k < NCNT; k++) begin : g_cnt
        kamus_counter #(.W(CNT_WIDTH)) u_cnt (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .inc_i     (inc_vec[k]),
            .inhibit_i (inh_vec[k]),
            .wr_lo_i   (do_wr && sel_cnt[k] && !sel_hi),
            .wr_hi_i   (do_wr && sel_cnt[k] && sel_hi),
            .wdata_i   (wr_val),
            .cnt_o     (cnt[k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc       <= '0;
            inhibit     <= '0;
            mtimecmp    <= '1;
            timer_irq_o <= 1'b0;
        end else begin
            presc <= tick ? 8'd0 : presc + 8'd1;
            if (do_wr && sel_inh) inhibit <= wr_val & INH_MASK;
            if (do_wr && sel_cmp && !sel_hi) mtimecmp[31:0] <= wr_val;
            if (do_wr && sel_cmp && sel_hi) mtimecmp[CNT_WIDTH-1:32] <= wr_val[CNT_WIDTH-33:0];
            timer_irq_o <= (cnt[2] >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_kamus_csr_counters.sv
// tb/tb_kamus_csr_counters.sv - directed scoreboard bench for kamus_csr_counters
module tb_kamus_csr_counters;
    import kamus_csr_counters_pkg::*;

    typedef struct packed {
        logic [31:0] rd;
        logic        hit;
        logic        ill;
        logic        chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, rst1_n;
    logic        which;
    logic        valid;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wd;
    logic        retire;
    logic [3:0]  hpm_ev;
    logic        irq0, irq1;
    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    kamus_csr_counters_if bus0 ();
    kamus_csr_counters_if bus1 ();

    assign bus0.csr_valid_i = valid && !which;
    assign bus0.csr_addr_i  = addr;
    assign bus0.csr_op_i    = op;
    assign bus0.csr_wdata_i = wd;
    assign bus1.csr_valid_i = valid && which;
    assign bus1.csr_addr_i  = addr;
    assign bus1.csr_op_i    = op;
    assign bus1.csr_wdata_i = wd;

    kamus_csr_counters #(.CNT_WIDTH(64), .NUM_HPM(4), .TIME_DIV(1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .csr            (bus0),
        .instr_retire_i (retire),
        .hpm_event_i    (hpm_ev),
        .timer_irq_o    (irq0)
    );

    kamus_csr_counters #(.CNT_WIDTH(40), .NUM_HPM(2), .TIME_DIV(4)) dut4 (
        .clk_i          (clk),
        .rst_ni         (rst_n && rst1_n),
        .csr            (bus1),
        .instr_retire_i (1'b0),
        .hpm_event_i    (2'b00),
        .timer_irq_o    (irq1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One access cycle, entered and left at posedge+1; outputs sampled on the negedge.
    task automatic acc(input logic w, input logic [11:0] a, input logic [1:0] o,
                       input logic [31:0] d, input logic [31:0] erd, input logic ehit,
                       input logic eill, input logic chk, input string tag);
        exp_t        e;
        string       t;
        logic [31:0] r;
        logic        h, il;
        which = w; valid = 1'b1; addr = a; op = o; wd = d;
        e.rd = erd; e.hit = ehit; e.ill = eill; e.chk = chk;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        r  = which ? bus1.csr_rdata_o   : bus0.csr_rdata_o;
        h  = which ? bus1.csr_hit_o     : bus0.csr_hit_o;
        il = which ? bus1.csr_illegal_o : bus0.csr_illegal_o;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (e.chk) check({t, "_rdata"}, r, e.rd);
        check({t, "_hit"}, 32'(h), 32'(e.hit));
        check({t, "_illegal"}, 32'(il), 32'(e.ill));
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic rd(input logic w, input logic [11:0] a, input logic [31:0] erd, input string tag);
        acc(w, a, F2_PRIV, 32'h0, erd, 1'b1, 1'b0, 1'b1, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        valid = 1'b0; which = 1'b0; addr = '0; op = '0; wd = '0;
        retire = 1'b0; hpm_ev = '0; rst_n = 1'b0; rst1_n = 1'b1;
        idle(3);

        // reset state
        check("rst_irq0", 32'(irq0), 32'd0);
        check("rst_irq1", 32'(irq1), 32'd0);
        rd(0, CYCLE, 32'h0, "rst_cycle");
        rd(0, MTIMECMPH, 32'hFFFF_FFFF, "rst_mtimecmph");
        rst_n = 1'b1;

        // idle after reset
        idle(10);
        rd(0, CYCLE, 32'd10, "cycle_10");
        rd(0, TIME, 32'd11, "time_11");
        rd(0, INSTRET, 32'd0, "instret_0");
        rd(0, CYCLEH, 32'd0, "cycleh_0");
        check("idle_irq0", 32'(irq0), 32'd0);

        // 64-bit wrap through half writes
        acc(0, MCYCLE, F2_CSRRW, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, "wr_mcycle");
        acc(0, MCYCLEH, F2_CSRRW, 32'hFFFF_FFFF, 32'h0, 1, 0, 1, "wr_mcycleh");
        rd(0, MCYCLEH, 32'hFFFF_FFFF, "mcycleh_ones");
        rd(0, MCYCLE, 32'h0, "mcycle_wrap_lo");
        rd(0, MCYCLEH, 32'h0, "mcycle_wrap_hi");

        // inhibit mask and minstret inhibit
        acc(0, MCOUNTINHIBIT, F2_CSRRW, 32'hFFFF_FFFF, 32'h0, 1, 0, 1, "inh_all");
        acc(0, MCOUNTINHIBIT, F2_CSRRW, 32'h4, 32'h7D, 1, 0, 1, "inh_mask");
        retire = 1'b1; idle(5); retire = 1'b0;
        rd(0, INSTRET, 32'd0, "instret_inhibited");
        acc(0, MCOUNTINHIBIT, F2_CSRRC, 32'h4, 32'h4, 1, 0, 1, "inh_clear");
        retire = 1'b1; idle(3); retire = 1'b0;
        rd(0, MINSTRET, 32'd3, "instret_plus3");

        // read-only shadows and set/clear semantics
        acc(0, CYCLE, F2_CSRRW, 32'h1234, 32'h0, 1, 1, 0, "cycle_ro");
        acc(0, INSTRET, F2_CSRRW, 32'hABC, 32'd3, 1, 1, 1, "instret_ro");
        rd(0, MINSTRET, 32'd3, "instret_unchanged");
        retire = 1'b1;
        acc(0, MINSTRET, F2_CSRRS, 32'h0, 32'd3, 1, 0, 1, "rs_zero");
        retire = 1'b0;
        rd(0, MINSTRET, 32'd4, "rs_zero_inc");
        acc(0, MINSTRET, F2_CSRRS, 32'h10, 32'd4, 1, 0, 1, "rs_set");
        acc(0, MINSTRET, F2_CSRRC, 32'h4, 32'h14, 1, 0, 1, "rc_clear");
        rd(0, MINSTRET, 32'h10, "rc_result");

        // hpm write wins over event, unimplemented and unknown addresses
        hpm_ev = 4'b0001;
        acc(0, MHPMCOUNTER3, F2_CSRRW, 32'd7, 32'd0, 1, 0, 1, "hpm3_wr");
        rd(0, MHPMCOUNTER3, 32'd7, "hpm3_write_wins");
        hpm_ev = 4'b0000;
        rd(0, MHPMCOUNTER3, 32'd8, "hpm3_inc");
        rd(0, MHPMCOUNTER3H, 32'd0, "hpm3h");
        acc(0, 12'hB07, F2_CSRRW, 32'd5, 32'd0, 1, 1, 1, "hpm_unimpl_wr");
        rd(0, 12'hB87, 32'd0, "hpm_unimpl_rd");
        acc(0, 12'h123, F2_CSRRW, 32'd5, 32'd0, 0, 0, 1, "unknown_addr");
        acc(0, 12'hB0B, F2_CSRRW, 32'd5, 32'd0, 0, 0, 1, "beyond_hpm_max");

        // no access when valid is low
        which = 1'b0; addr = MHPMCOUNTER3; op = F2_CSRRW; wd = 32'h55;
        @(negedge clk);
        check("novalid_rdata", bus0.csr_rdata_o, 32'h0);
        check("novalid_hit", 32'(bus0.csr_hit_o), 32'd0);
        check("novalid_illegal", 32'(bus0.csr_illegal_o), 32'd0);
        idle(1);
        rd(0, MHPMCOUNTER3, 32'd8, "novalid_nowrite");

        // timer interrupt on the TIME_DIV=4, 40-bit instance after a fresh reset
        rst1_n = 1'b0;
        idle(2);
        rd(1, MCYCLE, 32'd0, "rst1_mcycle");
        rst1_n = 1'b1;
        rd(1, MCYCLE, 32'd0, "rst1_first");
        rd(1, MTIMECMPH, 32'hFF, "cmph_reset40");
        acc(1, MTIMECMP, F2_CSRRW, 32'd20, 32'hFFFF_FFFF, 1, 0, 1, "cmp_wr");
        acc(1, MTIMECMPH, F2_CSRRW, 32'd0, 32'hFF, 1, 0, 1, "cmph_wr");
        idle(75);
        check("irq_before", 32'(irq1), 32'd0);
        idle(1);
        check("irq_at_match", 32'(irq1), 32'd0);
        rd(1, TIME, 32'd20, "time_20");
        check("irq_set", 32'(irq1), 32'd1);
        acc(1, MTIMECMP, F2_CSRRW, 32'd100, 32'd20, 1, 0, 1, "cmp_raise");
        check("irq_hold", 32'(irq1), 32'd1);
        idle(1);
        check("irq_clear", 32'(irq1), 32'd0);
        rd(1, TIMEH, 32'd0, "timeh_40");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
